aes128_key_schedule: RTL

Sequential AES-128 key schedule engine. It takes a 128-bit cipher key and iterates the one-round expansion function (RotWord, SubWord, Rcon XOR, chained column XOR) once per clock. The eleven round keys RK0..RK10 are stored in an internal buffer. The downstream cipher round datapath reads them through a registered read port, addressed by round number.

---
 rtl/aes128_key_schedule.sv | 137 +++++++++++++
 1 files changed

// File: rtl/aes128_key_schedule.sv
// rtl/aes128_key_schedule.sv - sequential AES-128 key expansion with registered round-key read port
// Each clock expands one round; RK0..RK10 are kept in a buffer that the cipher datapath reads by round index.
module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = SBOX[i_in];
endmodule

module aes128_key_schedule #(
  parameter int NR = 10,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [127:0]  i_key_in,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_keys_ready,
  input  logic [AW-1:0] i_rk_addr,
  input  logic          i_rk_rd,
  output logic [127:0]  o_rk_data,
  output logic          o_rk_valid
);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_round;
  logic [7:0]   r_rcon;
  logic [127:0] r_work;
  logic [127:0] r_rk [0:NR];
  logic         r_done;
  logic [127:0] r_rk_data;
  logic         r_rk_valid;

  logic         w_accept;
  logic         w_expand;
  logic         w_last;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [127:0] w_round_key;

  assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_expand = (r_state == S_EXPAND);
  assign w_last   = (r_round == 4'(NR));

  // RotWord of w3, then SubWord through four byte S-boxes
  assign w_rot = {r_work[23:0], r_work[31:24]};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.i_in(w_rot[8*g +: 8]), .o_out(w_sub[8*g +: 8]));
  end

  assign w_temp      = w_sub ^ {r_rcon, 24'h0};
  assign w_w0        = r_work[127:96] ^ w_temp;
  assign w_w1        = r_work[95:64]  ^ w_w0;
  assign w_w2        = r_work[63:32]  ^ w_w1;
  assign w_w3        = r_work[31:0]   ^ w_w2;
  assign w_round_key = {w_w0, w_w1, w_w2, w_w3};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_EXPAND;
      S_EXPAND: if (w_last)  w_next = S_DONE;
      S_DONE:   if (i_start) w_next = S_EXPAND;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_round    <= 4'd0;
      r_rcon     <= 8'h01;
      r_work     <= '0;
      r_done     <= 1'b0;
      r_rk_data  <= '0;
      r_rk_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_expand && w_last;
      if (w_accept) begin
        r_work  <= i_key_in;
        r_round <= 4'd1;
        r_rcon  <= 8'h01;
      end else if (w_expand) begin
        r_work  <= w_round_key;
        r_round <= r_round + 4'd1;
        r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
      // Reads see the buffer as it was before this edge, so a read racing a restart is still valid
      if (i_rk_rd && o_keys_ready && (i_rk_addr <= AW'(NR))) begin
        r_rk_data  <= r_rk[i_rk_addr];
        r_rk_valid <= 1'b1;
      end else begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_rk[0] <= i_key_in;
    end else if (w_expand) begin
      r_rk[r_round] <= w_round_key;
    end
  end

  assign o_busy       = (r_state == S_EXPAND);
  assign o_keys_ready = (r_state == S_DONE);
  assign o_done       = r_done;
  assign o_rk_data    = r_rk_data;
  assign o_rk_valid   = r_rk_valid;
endmodule
